// File: rtl/tqvp_ultrasonic_echo_emulator.sv
// rtl/tqvp_ultrasonic_echo_emulator.sv - multi-channel ultrasonic trigger/echo responder (optional jitter: SENSOR_EMU_JITTER_EN)
module tqvp_ultrasonic_echo_emulator #(
    parameter int CHANNELS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          address,
    input  logic [31:0]         data_in,
    input  logic [1:0]          data_write_n,
    input  logic [1:0]          data_read_n,
    output logic [31:0]         data_out,
    output logic                data_ready,
    input  logic [CHANNELS-1:0] trig,
    output logic [CHANNELS-1:0] echo,
    output logic                user_interrupt
);
    typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT, S_ECHO} state_t;

    logic                r_en, r_irq_en;
    logic [15:0]         r_width;
    logic [7:0]          r_trig_min;
    logic [CHANNELS-1:0] r_done, r_ovr;
    logic [15:0]         r_delay [CHANNELS];

    logic                w_wr, w_status_wr;
    logic [7:0]          w_tmin_eff;
    logic [CHANNELS-1:0] w_busy, w_done_set, w_ovr_set, w_clr_done, w_clr_ovr;
    logic [31:0]         w_rdata;
    logic                w_unused;

    assign w_wr        = (data_write_n != 2'b11);
    assign w_status_wr = w_wr && (address == 6'h0C);
    assign w_tmin_eff  = (r_trig_min == 8'd0) ? 8'd1 : r_trig_min;
    assign w_clr_done  = w_status_wr ? data_in[CHANNELS-1:0] : '0;
    assign w_clr_ovr   = w_status_wr ? data_in[16 +: CHANNELS] : '0;
    assign w_unused    = &{1'b0, data_read_n, data_in};

`ifdef SENSOR_EMU_JITTER_EN
    logic [15:0] r_lfsr;
    always_ff @(posedge clk) begin
        if (!rst_n) r_lfsr <= 16'hACE1;
        else        r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_en       <= 1'b0;
            r_irq_en   <= 1'b0;
            r_width    <= 16'd0;
            r_trig_min <= 8'd10;
            for (int i = 0; i < CHANNELS; i++) r_delay[i] <= 16'd0;
        end else if (w_wr) begin
            if (address == 6'h00) {r_irq_en, r_en} <= data_in[1:0];
            if (address == 6'h04) r_width <= data_in[15:0];
            if (address == 6'h08) r_trig_min <= data_in[7:0];
            for (int i = 0; i < CHANNELS; i++)
                if (address == 6'(32 + 4 * i)) r_delay[i] <= data_in[15:0];
        end
    end

    // A completion or overrun in the same cycle as its W1C wins over the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_done <= '0;
            r_ovr  <= '0;
        end else begin
            r_done <= (r_done & ~w_clr_done) | w_done_set;
            r_ovr  <= (r_ovr & ~w_clr_ovr) | w_ovr_set;
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        state_t      r_state, w_state_nx;
        logic [15:0] r_cnt, w_cnt_nx, w_delay_ld;
        logic [7:0]  r_hi, w_hi_nx;
        logic        r_echo, r_trig_q, w_echo_nx;

`ifdef SENSOR_EMU_JITTER_EN
        logic [16:0] w_sum;
        assign w_sum      = {1'b0, r_delay[ch]} + {14'd0, r_lfsr[2:0]};
        assign w_delay_ld = w_sum[16] ? 16'hFFFF : w_sum[15:0];
`else
        assign w_delay_ld = r_delay[ch];
`endif

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_state  <= S_IDLE;
                r_cnt    <= 16'd0;
                r_hi     <= 8'd0;
                r_echo   <= 1'b0;
                r_trig_q <= 1'b0;
            end else begin
                r_state  <= w_state_nx;
                r_cnt    <= w_cnt_nx;
                r_hi     <= w_hi_nx;
                r_echo   <= w_echo_nx;
                r_trig_q <= trig[ch];
            end
        end

        always_comb begin
            w_state_nx = r_state;
            w_cnt_nx   = r_cnt;
            w_hi_nx    = r_hi;
            if (!r_en) begin
                w_state_nx = S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: if (trig[ch]) begin
                        w_state_nx = S_ARM;
                        w_hi_nx    = 8'd1;
                    end
                    S_ARM: begin
                        if (trig[ch]) begin
                            if (r_hi != 8'hFF) w_hi_nx = r_hi + 8'd1;
                        end else if (r_hi >= w_tmin_eff) begin
                            w_state_nx = S_WAIT;
                            w_cnt_nx   = w_delay_ld;
                        end else begin
                            w_state_nx = S_IDLE;
                        end
                    end
                    S_WAIT: begin
                        if (r_cnt != 16'd0) begin
                            w_cnt_nx = r_cnt - 16'd1;
                        end else if (r_width == 16'd0) begin
                            w_state_nx = S_IDLE;
                        end else begin
                            w_state_nx = S_ECHO;
                            w_cnt_nx   = r_width - 16'd1;
                        end
                    end
                    S_ECHO: begin
                        if (r_cnt != 16'd0) w_cnt_nx = r_cnt - 16'd1;
                        else                w_state_nx = S_IDLE;
                    end
                    default: w_state_nx = S_IDLE;
                endcase
            end
        end

        always_comb begin
            w_echo_nx = (w_state_nx == S_ECHO);
            w_busy[ch] = (r_state != S_IDLE);
            w_done_set[ch] = r_en && (r_cnt == 16'd0) &&
                             (((r_state == S_WAIT) && (r_width == 16'd0)) || (r_state == S_ECHO));
            w_ovr_set[ch] = r_en && ((r_state == S_WAIT) || (r_state == S_ECHO)) &&
                            trig[ch] && !r_trig_q;
        end

        assign echo[ch] = r_echo;
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            6'h00: w_rdata[1:0] = {r_irq_en, r_en};
            6'h04: w_rdata[15:0] = r_width;
            6'h08: w_rdata[7:0] = r_trig_min;
            6'h0C: begin
                w_rdata[CHANNELS-1:0]  = r_done;
                w_rdata[16 +: CHANNELS] = r_ovr;
            end
            6'h10: w_rdata[CHANNELS-1:0] = w_busy;
`ifdef SENSOR_EMU_JITTER_EN
            6'h14: w_rdata[15:0] = r_lfsr;
`endif
            default: begin
                for (int i = 0; i < CHANNELS; i++)
                    if (address == 6'(32 + 4 * i)) w_rdata[15:0] = r_delay[i];
            end
        endcase
    end

    assign data_out       = w_rdata;
    assign data_ready     = 1'b1;
    assign user_interrupt = r_irq_en & (|r_done);
endmodule

// File: tb/tb_tqvp_ultrasonic_echo_emulator.sv
// tb/tb_tqvp_ultrasonic_echo_emulator.sv - scoreboard bench for the ultrasonic echo emulator
module tb_tqvp_ultrasonic_echo_emulator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  address = '0;
    logic [31:0] data_in = '0;
    logic [1:0]  data_write_n = 2'b11;
    logic [1:0]  data_read_n = 2'b11;
    logic [31:0] data_out;
    logic        data_ready;
    logic [7:0]  trig = '0;
    logic [7:0]  echo;
    logic        user_interrupt;

    tqvp_ultrasonic_echo_emulator #(.CHANNELS(8)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .data_in(data_in),
        .data_write_n(data_write_n), .data_read_n(data_read_n), .data_out(data_out),
        .data_ready(data_ready), .trig(trig), .echo(echo), .user_interrupt(user_interrupt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {int ch; int rise; int width; bit chkw;} exp_t;
    exp_t sb[$];

    task automatic push(input int ch, input int rise, input int width, input bit chkw);
        exp_t e;
        e.ch = ch; e.rise = rise; e.width = width; e.chkw = chkw;
        sb.push_back(e);
    endtask

    logic [7:0] echo_q = '0;
    int         rise_at [8];

    always @(negedge clk) begin
        for (int ch = 0; ch < 8; ch++) begin
            int idx;
            idx = -1;
            for (int k = 0; k < sb.size(); k++)
                if (idx < 0 && sb[k].ch == ch) idx = k;
            if (echo[ch] === 1'b1 && echo_q[ch] == 1'b0) begin
                rise_at[ch] = cyc;
                if (idx < 0) check($sformatf("echo_unexpected_ch%0d", ch), 1, 0);
                else         check($sformatf("echo_rise_ch%0d", ch), cyc, sb[idx].rise);
            end
            if (echo[ch] === 1'b0 && echo_q[ch] == 1'b1 && idx >= 0) begin
                if (sb[idx].chkw)
                    check($sformatf("echo_width_ch%0d", ch), cyc - rise_at[ch], sb[idx].width);
                sb.delete(idx);
            end
        end
        echo_q = (echo === 8'bx) ? 8'h00 : echo;
    end

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; data_in = d; data_write_n = 2'b00;
        @(negedge clk);
        data_write_n = 2'b11;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = data_out;
    endtask

    task automatic rd_check(input string tag, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(tag, d, exp);
    endtask

    // f = the first edge that samples trig low after the pulse
    task automatic pulse(input logic [7:0] m, input int len, output int f);
        @(negedge clk);
        trig = trig | m;
        f = cyc + 1 + len;
        repeat (len) @(negedge clk);
        trig = trig & ~m;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, input int max);
        logic [31:0] d;
        int n;
        n = 0;
        rd(6'h10, d);
        while (d != 0 && n < max) begin
            @(negedge clk);
            rd(6'h10, d);
            n++;
        end
        if (d != 0) check({tag, "_timeout"}, 1, 0);
    endtask

    initial begin
        int f;
        int seen;
        logic [31:0] d;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd_check("rst_ctrl", 6'h00, 32'h0);
        rd_check("rst_width", 6'h04, 32'h0);
        rd_check("rst_trig_min", 6'h08, 32'd10);
        rd_check("rst_status", 6'h0C, 32'h0);
        rd_check("rst_busy", 6'h10, 32'h0);
        rd_check("rst_lfsr_addr", 6'h14, 32'h0);
        rd_check("rst_delay0", 6'h20, 32'h0);
        rd_check("unmapped", 6'h18, 32'h0);
        check("rst_echo", echo, 8'h00);
        check("rst_irq", user_interrupt, 0);
        check("data_ready", data_ready, 1);

        // nominal
        wr(6'h00, 32'h1);
        wr(6'h04, 32'd50);
        wr(6'h20, 32'd100);
        rd_check("delay0_rb", 6'h20, 32'd100);
        pulse(8'h01, 12, f);
        push(0, f + 101, 50, 1);
        wait_idle("nominal", 400);
        rd_check("nominal_status", 6'h0C, 32'h1);
        check("nominal_irq_off", user_interrupt, 0);
        wr(6'h0C, 32'h1);
        rd_check("nominal_clr", 6'h0C, 32'h0);

        // runt: 5 and 9 cycles with TRIG_MIN=10
        pulse(8'h08, 5, f);
        @(negedge clk);
        wait_idle("runt5", 5);
        rd_check("runt5_busy", 6'h10, 32'h0);
        pulse(8'h08, 9, f);
        repeat (20) @(negedge clk);
        rd_check("runt_status", 6'h0C, 32'h0);

        // WIDTH=0, exact TRIG_MIN qualification
        wr(6'h04, 32'd0);
        wr(6'h28, 32'd7);
        pulse(8'h04, 10, f);
        seen = -1;
        for (int n = 0; n < 100 && seen < 0; n++) begin
            rd(6'h0C, d);
            if (d[2]) seen = cyc;
            else @(negedge clk);
        end
        check("w0_done_edge", seen, f + 8);
        wr(6'h0C, 32'h4);

        // DELAY=0, WIDTH=1
        wr(6'h04, 32'd1);
        wr(6'h30, 32'd0);
        pulse(8'h10, 10, f);
        push(4, f + 1, 1, 1);
        wait_idle("d0w1", 50);
        rd_check("d0w1_status", 6'h0C, 32'h10);
        wr(6'h0C, 32'h10);

        // TRIG_MIN=0 behaves as 1
        wr(6'h08, 32'd0);
        wr(6'h34, 32'd3);
        pulse(8'h20, 1, f);
        push(5, f + 4, 1, 1);
        wait_idle("tmin0", 50);
        wr(6'h08, 32'd10);
        wr(6'h0C, 32'h20);

        // overrun during ECHO
        wr(6'h04, 32'd20);
        wr(6'h24, 32'd5);
        pulse(8'h02, 12, f);
        push(1, f + 6, 20, 1);
        wait_cyc(f + 10);
        pulse(8'h02, 3, seen);
        wait_idle("ovr", 100);
        rd_check("ovr_status", 6'h0C, 32'h0002_0002);
        wr(6'h0C, 32'h0002_0002);
        rd_check("ovr_clr", 6'h0C, 32'h0);

        // simultaneous completion with interrupt enabled
        wr(6'h00, 32'h3);
        wr(6'h04, 32'd3);
        wr(6'h20, 32'd4);
        wr(6'h3C, 32'd4);
        pulse(8'h81, 10, f);
        push(0, f + 5, 3, 1);
        push(7, f + 5, 3, 1);
        wait_idle("irq", 50);
        rd_check("irq_status", 6'h0C, 32'h81);
        check("irq_set", user_interrupt, 1);
        wr(6'h0C, 32'h81);
        check("irq_clr", user_interrupt, 0);

        // disable during WAIT
        wr(6'h38, 32'd50);
        pulse(8'h40, 12, f);
        repeat (5) @(negedge clk);
        rd_check("dis_busy_wait", 6'h10, 32'h40);
        wr(6'h00, 32'h0);
        @(negedge clk);
        rd_check("dis_busy", 6'h10, 32'h0);
        check("dis_echo", echo, 8'h00);
        rd_check("dis_status", 6'h0C, 32'h0);
        repeat (70) @(negedge clk);
        wr(6'h00, 32'h1);

        // reset mid-ECHO
        wr(6'h08, 32'd15);
        wr(6'h04, 32'd40);
        wr(6'h20, 32'd2);
        pulse(8'h01, 16, f);
        push(0, f + 3, 0, 0);
        wait_cyc(f + 13);
        check("pre_rst_echo", echo[0], 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst2_echo", echo, 8'h00);
        rd_check("rst2_status", 6'h0C, 32'h0);
        rd_check("rst2_trig_min", 6'h08, 32'd10);
        rd_check("rst2_busy", 6'h10, 32'h0);
        @(negedge clk);

        check("sb_left", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tqvp_ultrasonic_echo_emulator.md
# tqvp_ultrasonic_echo_emulator

Multi-channel ultrasonic sensor emulator: the responder side of the trigger/echo protocol. Each channel watches its `trig` input, qualifies a trigger pulse, waits a programmable per-channel flight time, then drives `echo` high for a programmable width. It sits as a TinyQV peripheral on the register bus and is looped back to a sensor-response checker on the same die, or driven out to pins for board-level bring-up.

## Interface
- `CHANNELS`, default 8: number of emulated sensors; legal range 1..8.
- `clk` in 1: clock. Reset `rst_n` is synchronous and active-low; clock is `clk`.
- `rst_n` in 1: synchronous active-low reset.
- `address` in 6: register byte address.
- `data_in` in 32: write data. All writes load the full 32 bits, masked to each field width.
- `data_write_n` in 2: `11` means no write; any other value is a write this cycle.
- `data_read_n` in 2: read strobe. Unused, because reads are combinational.
- `data_out` out 32: read data, decoded from `address`. Reset reads reflect reset register values.
- `data_ready` out 1: tied to 1.
- `trig` in CHANNELS: trigger inputs, synchronous to `clk`.
- `echo` out CHANNELS: registered echo outputs. Reset value is 0.
- `user_interrupt` out 1: equals `CTRL.irq_en & |STATUS.done`. Reset value is 0.

## Operation
Register map (reset values in brackets):
- 0x00 `CTRL`: bit0 `en` [0], bit1 `irq_en` [0].
- 0x04 `WIDTH`: [15:0] echo width in cycles [0].
- 0x08 `TRIG_MIN`: [7:0] minimum trigger-high cycles [10]. A value of 0 behaves as 1.
- 0x0C `STATUS`: [CH-1:0] `done` sticky; [CH+15:16] `overrun` sticky. Both are write-1-to-clear. A set and a clear in the same cycle resolve to set.
- 0x10 `BUSY`, read-only: bit i is 1 when channel i is not IDLE.
- 0x20+4i `DELAY[i]`: [15:0] flight time [0], for i < CHANNELS.
- Unmapped addresses read 0 and ignore writes.

Per-channel FSM. Each channel has a 16-bit `cnt`, an 8-bit saturating `hi`, and a registered copy `trig_q`.
- IDLE: when `trig` is sampled high, go to ARM with `hi`=1.
- ARM:
  - If `trig` is high, `hi` increments and saturates at 255.
  - If `trig` is low and `hi` >= TRIG_MIN, go to WAIT with `cnt` = `DELAY[i]`.
  - If `trig` is low and `hi` < TRIG_MIN, the pulse is a runt. Return to IDLE with no flags set.
- WAIT:
  - If `cnt` != 0, decrement `cnt`.
  - Else if `WIDTH` = 0, go to IDLE and set `done[i]`. No echo is produced (models a missing return).
  - Else go to ECHO with `echo[i]`=1 and `cnt` = `WIDTH`-1.
- ECHO:
  - If `cnt` != 0, decrement `cnt`.
  - Else go to IDLE with `echo[i]`=0 and set `done[i]`.
- A rising `trig` edge (`trig & ~trig_q`) in WAIT or ECHO sets `overrun[i]`. The edge is otherwise ignored and the FSM continues.
- `DELAY` and `WIDTH` are sampled only on entry to WAIT and ECHO. Writes made mid-flight affect the next trigger only.
- `en`=0 forces every FSM to IDLE and every `echo` low on the next edge, without touching STATUS.
- Reset places all FSMs in IDLE, sets `echo`=0, clears STATUS, and applies register reset values.

## Timing
- Let edge F be the first edge that samples `trig` low in ARM with the trigger qualified.
- `echo` rises at edge F+DELAY+1 and stays high for exactly WIDTH cycles.
- `done` sets on the same edge that `echo` falls.
- With DELAY=0, `echo` rises at edge F+1.
- Trigger qualification: `trig` must be sampled high on at least TRIG_MIN consecutive edges, counted from the IDLE edge that first samples it high.
- Register writes take effect on the edge of the write cycle. The new value is readable on the next cycle.
- `user_interrupt` follows STATUS with no extra latency beyond the register.

## Configuration
- `SENSOR_EMU_JITTER_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 0xACE1) advances every cycle.
  - On WAIT entry, `cnt` is loaded with `DELAY[i]` + `lfsr[2:0]`, with 16-bit saturation.
  - Address 0x14 reads the current LFSR value.
- Not defined: the delay is exactly `DELAY[i]`, no LFSR logic is present, and 0x14 reads 0.

## Test plan
- Nominal: `en`=1, TRIG_MIN=10, DELAY[0]=100, WIDTH=50. Drive `trig[0]` high for 12 cycles. Expect `echo[0]` to rise at F+101, stay high 50 cycles, then `done[0]`=1.
- Runt: `trig[3]` high for 5 cycles with TRIG_MIN=10. Expect no echo, BUSY back to 0, STATUS unchanged.
- Zero cases:
  - WIDTH=0: expect no echo pulse and `done` set at F+DELAY+1.
  - DELAY=0, WIDTH=1: expect a 1-cycle echo at F+1.
- Overrun: re-pulse `trig[1]` during its ECHO phase. Expect `overrun[1]`=1, echo width unchanged. Then W1C 0x00020002 clears both `done[1]` and `overrun[1]`.
- Interrupt and disable:
  - `irq_en`=1, complete channels 0 and 7 simultaneously: expect `user_interrupt`=1 with STATUS[7:0]=0x81.
  - Clear `en` during WAIT: expect `echo`=0 and BUSY=0 on the next edge.
- Reset mid-ECHO: assert `rst_n`=0 for 1 cycle. Expect `echo`=0, STATUS=0, TRIG_MIN reads 10.
